word_divider: RTL and testbench
===============================

WORD_DIVIDER -- requirements
Module: word_divider

Interface
REQ-001 SHALL take parameter/define `WordWidth, default 32, as the operand and result width.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port in_Clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port in_nReset, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_Start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-006 SHALL have port in_Dividend, input, `WordWidth bits: numerator, captured on accept.
REQ-007 SHALL have port in_Divisor, input, `WordWidth bits: denominator, captured on accept.
REQ-008 SHALL have port in_Signed, input, 1 bit: two's-complement operation; present only with DIV_SIGNED_EN.
REQ-009 SHALL have port out_Busy, output, 1 bit: high in RUN and DONE.
REQ-010 SHALL have port out_Valid, output, 1 bit: single-cycle result strobe.
REQ-011 SHALL have ports out_Quotient and out_Remainder, output, `WordWidth bits each: results, held until the next accept.
REQ-012 SHALL have ports out_Zero, out_Neg, out_DivZero and out_Overflow, output, 1 bit each: status flags, held with the results.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with in_Start=1, capture the operands, clear the partial remainder, load iteration counter = `WordWidth-1 and enter RUN.
REQ-015 SHALL, in RUN, produce one quotient bit per cycle by restoring shift-subtract, MSB first: shift the remainder left 1 and bring in the next dividend bit; if the trial difference is non-negative, keep it and set the quotient bit to 1.
REQ-016 SHALL leave RUN after exactly `WordWidth cycles, with the counter reaching 0, and enter DONE.
REQ-017 SHALL, in DONE, register the results and flags, pulse out_Valid for 1 cycle and return to IDLE.
REQ-018 SHALL have a latency of `WordWidth+1 cycles from the accept edge to out_Valid high (33 cycles at default width).
REQ-019 SHALL ignore in_Start while out_Busy=1, with no effect on the operation in flight.
REQ-020 SHALL accept a new in_Start in the cycle after out_Valid.
REQ-021 SHALL handle divisor==0 by skipping RUN: DONE on the next cycle with quotient all ones, remainder = dividend and out_DivZero=1.
REQ-022 SHALL set out_Zero = (quotient==0) and out_Neg = quotient MSB.
REQ-023 SHALL hold out_Overflow at 0 unless a signed overflow occurs (REQ-029).
REQ-024 SHALL compute all arithmetic at `WordWidth+1 bits internally so the trial difference sign bit is exact; no truncation before result registration.

Reset
REQ-025 SHALL, on in_nReset low at any time, including mid-RUN, immediately force IDLE, counter 0, out_Busy=0, out_Valid=0, out_Quotient=0, out_Remainder=0 and all flags 0.
REQ-026 SHALL discard an aborted operation and produce no out_Valid for it after reset release.

Configuration
REQ-027 SHALL support the macro DIV_SIGNED_EN; when it is undefined, in_Signed is absent and all operation is unsigned.
REQ-028 SHALL, when DIV_SIGNED_EN is defined and in_Signed=1, divide operand magnitudes, give the quotient sign = sign(dividend) XOR sign(divisor), and give the remainder the dividend's sign; fix-up applied in DONE with no added latency.
REQ-029 SHALL, for the signed case 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000, remainder 0 and out_Overflow=1.
REQ-030 SHALL, for a signed divide by zero, return quotient 0xFFFFFFFF and remainder = dividend.

Structure
REQ-031 SHALL take `WordWidth from the shared structure-parameter define file; FSM state encodings and the iteration counter width (log2(`WordWidth)+1) SHALL live in the same shared definitions.
REQ-032 SHALL use one sub-module, word_subtractor: a combinational (`WordWidth+1)-bit trial subtract returning the difference and a borrow.

Verification
REQ-033 SHALL cover: unsigned 0x00001011 / 0x00000010 -> Q=0x00000101, R=0x00000001, out_Valid at cycle 33, flags 0.
REQ-034 SHALL cover: 0x70001011 / 0x0 -> out_Valid 2 cycles after accept, Q=0xFFFFFFFF, R=0x70001011, out_DivZero=1.
REQ-035 SHALL cover: 0x00000005 / 0x00000007 -> Q=0, R=5, out_Zero=1; a second in_Start at cycle 10 is ignored.
REQ-036 SHALL cover (DIV_SIGNED_EN): in_Signed=1, 0xFFFFFFF9 (-7) / 0x00000002 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1), out_Neg=1; and 0x80000000 / 0xFFFFFFFF -> out_Overflow=1.
REQ-037 SHALL cover: in_nReset low at RUN cycle 15 -> all outputs 0 asynchronously, no out_Valid afterwards; a new divide completes correctly.
REQ-038 SHALL cover: back-to-back starts (in_Start held high) -> accepts one cycle after each out_Valid, with results matching a reference model over 1000 random pairs.

Source files
------------

// File: rtl/word_divider_pkg.sv
// Shared definitions for the word divider: word width, iteration counter width, FSM encoding.
// Optional feature macro: DIV_SIGNED_EN (two's-complement divide via in_Signed).
`ifndef WordWidth
`define WordWidth 32
`endif

package word_divider_pkg;

    localparam int unsigned WordWidth = `WordWidth;
    localparam int unsigned CntWidth  = $clog2(WordWidth) + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Two's-complement negation at word width.
    function automatic logic [WordWidth-1:0] negate(input logic [WordWidth-1:0] value);
        return ~value + WordWidth'(1);
    endfunction

endpackage

// File: rtl/word_divider_if.sv
// Request/result bundle for the word divider.
// Optional feature macro: DIV_SIGNED_EN adds in_Signed.
interface word_divider_if;
    import word_divider_pkg::*;

    logic                 in_Start;
    logic [WordWidth-1:0] in_Dividend;
    logic [WordWidth-1:0] in_Divisor;
`ifdef DIV_SIGNED_EN
    logic                 in_Signed;
`endif
    logic                 out_Busy;
    logic                 out_Valid;
    logic [WordWidth-1:0] out_Quotient;
    logic [WordWidth-1:0] out_Remainder;
    logic                 out_Zero;
    logic                 out_Neg;
    logic                 out_DivZero;
    logic                 out_Overflow;

    modport master (
`ifdef DIV_SIGNED_EN
        output in_Signed,
`endif
        output in_Start, in_Dividend, in_Divisor,
        input  out_Busy, out_Valid, out_Quotient, out_Remainder,
        input  out_Zero, out_Neg, out_DivZero, out_Overflow
    );

    modport slave (
`ifdef DIV_SIGNED_EN
        input  in_Signed,
`endif
        input  in_Start, in_Dividend, in_Divisor,
        output out_Busy, out_Valid, out_Quotient, out_Remainder,
        output out_Zero, out_Neg, out_DivZero, out_Overflow
    );

endinterface

// File: rtl/word_subtractor.sv
// Combinational (WordWidth+1)-bit trial subtract for the restoring divider.
module word_subtractor
    import word_divider_pkg::*;
(
    input  logic [WordWidth:0] minuend,
    input  logic [WordWidth:0] subtrahend,
    output logic [WordWidth:0] difference,
    output logic               borrow
);

    // Extra top bit of the widened subtract is the borrow out.
    always_comb begin
        {borrow, difference} = {1'b0, minuend} - {1'b0, subtrahend};
    end

endmodule

// File: rtl/word_divider.sv
// Multi-cycle restoring shift-subtract divider: one quotient bit per cycle, MSB first.
// Optional feature macro: DIV_SIGNED_EN (in_Signed selects two's-complement operation).
module word_divider
    import word_divider_pkg::*;
(
    input  logic          in_Clock,
    input  logic          in_nReset,
    word_divider_if.slave bus
);

    div_state_e           state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    // Dividend shifts out at the MSB while quotient bits shift in at the LSB.
    logic [WordWidth-1:0] dvd_q, dvd_d;
    logic [WordWidth-1:0] dsr_q, dsr_d;
    logic [WordWidth-1:0] rem_q, rem_d;
    logic [WordWidth-1:0] orig_q, orig_d;
    logic                 div_zero_q, div_zero_d;
`ifdef DIV_SIGNED_EN
    logic                 quot_neg_q, quot_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 ovf_q, ovf_d;
    logic                 cap_quot_neg, cap_rem_neg, cap_ovf;
`endif

    logic                 valid_q, valid_d;
    logic [WordWidth-1:0] quot_out_q, quot_out_d;
    logic [WordWidth-1:0] rem_out_q, rem_out_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 dz_out_q, dz_out_d;
    logic                 ovf_out_q, ovf_out_d;

    logic [WordWidth:0]   rem_shift;
    logic [WordWidth:0]   trial_diff;
    logic                 trial_borrow;
    logic                 unused_diff_msb;
    logic [WordWidth-1:0] cap_dvd, cap_dsr;
    logic [WordWidth-1:0] fix_quot, fix_rem;

    assign rem_shift       = {rem_q, dvd_q[WordWidth-1]};
    // A successful trial always leaves a difference below the divisor, so its MSB is zero.
    assign unused_diff_msb = trial_diff[WordWidth];

    word_subtractor u_sub (
        .minuend    (rem_shift),
        .subtrahend ({1'b0, dsr_q}),
        .difference (trial_diff),
        .borrow     (trial_borrow)
    );

    // Operand conditioning at accept: signed requests divide magnitudes and remember the signs.
    always_comb begin
        cap_dvd = bus.in_Dividend;
        cap_dsr = bus.in_Divisor;
`ifdef DIV_SIGNED_EN
        cap_quot_neg = 1'b0;
        cap_rem_neg  = 1'b0;
        cap_ovf      = 1'b0;
        if (bus.in_Signed) begin
            if (bus.in_Dividend[WordWidth-1]) cap_dvd = negate(bus.in_Dividend);
            if (bus.in_Divisor[WordWidth-1])  cap_dsr = negate(bus.in_Divisor);
            cap_quot_neg = bus.in_Dividend[WordWidth-1] ^ bus.in_Divisor[WordWidth-1];
            cap_rem_neg  = bus.in_Dividend[WordWidth-1];
            cap_ovf      = (bus.in_Dividend == {1'b1, {(WordWidth-1){1'b0}}}) &&
                           (bus.in_Divisor == '1);
        end
`endif
    end

    // Result fix-up used in DONE: divide-by-zero pattern, else sign restoration.
    always_comb begin
        fix_quot = dvd_q;
        fix_rem  = rem_q;
        if (div_zero_q) begin
            fix_quot = '1;
            fix_rem  = orig_q;
        end
`ifdef DIV_SIGNED_EN
        else begin
            if (quot_neg_q) fix_quot = negate(dvd_q);
            if (rem_neg_q)  fix_rem  = negate(rem_q);
        end
`endif
    end

    // Next-state and datapath control for IDLE -> RUN -> DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        orig_d     = orig_q;
        div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        ovf_d      = ovf_q;
`endif
        valid_d    = 1'b0;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        dz_out_d   = dz_out_q;
        ovf_out_d  = ovf_out_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_Start) begin
                    dvd_d      = cap_dvd;
                    dsr_d      = cap_dsr;
                    orig_d     = bus.in_Dividend;
                    div_zero_d = (bus.in_Divisor == '0);
                    rem_d      = '0;
                    cnt_d      = CntWidth'(WordWidth - 1);
`ifdef DIV_SIGNED_EN
                    quot_neg_d = cap_quot_neg;
                    rem_neg_d  = cap_rem_neg;
                    ovf_d      = cap_ovf;
`endif
                    state_d    = StRun;
                end
            end
            StRun: begin
                // Zero divisor leaves after the first cycle without iterating.
                if (div_zero_q) begin
                    state_d = StDone;
                end else begin
                    rem_d = trial_borrow ? rem_shift[WordWidth-1:0] : trial_diff[WordWidth-1:0];
                    dvd_d = {dvd_q[WordWidth-2:0], ~trial_borrow};
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end
            end
            StDone: begin
                valid_d    = 1'b1;
                quot_out_d = fix_quot;
                rem_out_d  = fix_rem;
                zero_d     = (fix_quot == '0);
                neg_d      = fix_quot[WordWidth-1];
                dz_out_d   = div_zero_q;
`ifdef DIV_SIGNED_EN
                ovf_out_d  = ovf_q & ~div_zero_q;
`else
                ovf_out_d  = 1'b0;
`endif
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge in_Clock or negedge in_nReset) begin
        if (!in_nReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            orig_q     <= '0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            ovf_q      <= 1'b0;
`endif
            valid_q    <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            dz_out_q   <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            orig_q     <= orig_d;
            div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            ovf_q      <= ovf_d;
`endif
            valid_q    <= valid_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            dz_out_q   <= dz_out_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign bus.out_Busy      = (state_q != StIdle);
    assign bus.out_Valid     = valid_q;
    assign bus.out_Quotient  = quot_out_q;
    assign bus.out_Remainder = rem_out_q;
    assign bus.out_Zero      = zero_q;
    assign bus.out_Neg       = neg_q;
    assign bus.out_DivZero   = dz_out_q;
    assign bus.out_Overflow  = ovf_out_q;

endmodule

// File: tb/tb_word_divider.sv
// Self-checking bench for word_divider: directed vector table plus multi-cycle corner sequences.
module tb_word_divider;

    logic clk;
    logic rst_n;

    word_divider_if bus ();

    word_divider dut (
        .in_Clock  (clk),
        .in_nReset (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  flags;  // {zero, neg, divzero, overflow}
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.out_Zero, bus.out_Neg, bus.out_DivZero, bus.out_Overflow};
    endfunction

    // Counts edges after an accept until out_Valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_Valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        bus.in_Dividend = a;
        bus.in_Divisor  = b;
`ifdef DIV_SIGNED_EN
        bus.in_Signed   = sgn;
`else
        if (sgn) $display("note: signed vector driven unsigned");
`endif
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int lat);
        @(negedge clk);
        drive(a, b, sgn);
        bus.in_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.in_Start = 1'b0;
        wait_valid(lat);
    endtask

    int          lat;
    int          seen;
    logic [31:0] ra, rb, eq, er;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_Start = 1'b0;
        drive(32'h0, 32'h0, 1'b0);

        vecs.push_back('{"u_basic",  32'h0000_1011, 32'h0000_0010, 1'b0,
                         32'h0000_0101, 32'h0000_0001, 4'b0000, 33});
        vecs.push_back('{"u_small",  32'h0000_0005, 32'h0000_0007, 1'b0,
                         32'h0000_0000, 32'h0000_0005, 4'b1000, 33});
        vecs.push_back('{"u_divz",   32'h7000_1011, 32'h0000_0000, 1'b0,
                         32'hFFFF_FFFF, 32'h7000_1011, 4'b0110, 2});
        vecs.push_back('{"u_max_1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
                         32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 33});
        vecs.push_back('{"u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                         32'h0000_0001, 32'h0000_0000, 4'b0000, 33});
        vecs.push_back('{"u_100_10", 32'd100, 32'd10, 1'b0,
                         32'd10, 32'd0, 4'b0000, 33});
        vecs.push_back('{"u_min_3",  32'h8000_0000, 32'h0000_0003, 1'b0,
                         32'h2AAA_AAAA, 32'h0000_0002, 4'b0000, 33});
        vecs.push_back('{"u_zero_n", 32'h0000_0000, 32'h0000_0005, 1'b0,
                         32'h0000_0000, 32'h0000_0000, 4'b1000, 33});
        vecs.push_back('{"u_shift",  32'h1234_5678, 32'h0000_1000, 1'b0,
                         32'h0001_2345, 32'h0000_0678, 4'b0000, 33});
        vecs.push_back('{"u_lt_big", 32'h0000_0003, 32'hFFFF_FFFF, 1'b0,
                         32'h0000_0000, 32'h0000_0003, 4'b1000, 33});
        vecs.push_back('{"u_neg7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b0,
                         32'h7FFF_FFFC, 32'h0000_0001, 4'b0000, 33});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{"s_neg7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1,
                         32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0100, 33});
        vecs.push_back('{"s_7_neg2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1,
                         32'hFFFF_FFFD, 32'h0000_0001, 4'b0100, 33});
        vecs.push_back('{"s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                         32'h8000_0000, 32'h0000_0000, 4'b0101, 33});
        vecs.push_back('{"s_divz",   32'hFFFF_FFFB, 32'h0000_0000, 1'b1,
                         32'hFFFF_FFFF, 32'hFFFF_FFFB, 4'b0110, 2});
`endif

        // Reset state
        #1;
        check("rst_busy",  64'(bus.out_Busy), 64'd0);
        check("rst_valid", 64'(bus.out_Valid), 64'd0);
        check("rst_q",     64'(bus.out_Quotient), 64'd0);
        check("rst_r",     64'(bus.out_Remainder), 64'd0);
        check("rst_flags", 64'(flags_now()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
            check({vecs[i].name, "_lat"},   64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_q"},     64'(bus.out_Quotient), 64'(vecs[i].q));
            check({vecs[i].name, "_r"},     64'(bus.out_Remainder), 64'(vecs[i].r));
            check({vecs[i].name, "_flags"}, 64'(flags_now()), 64'(vecs[i].flags));
            @(posedge clk);
            #1;
            check({vecs[i].name, "_pulse"}, 64'(bus.out_Valid), 64'd0);
        end

        // Start while busy is ignored
        @(negedge clk);
        drive(32'd5, 32'd7, 1'b0);
        bus.in_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.in_Start = 1'b0;
        check("ign_busy", 64'(bus.out_Busy), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        drive(32'd100, 32'd3, 1'b0);
        bus.in_Start = 1'b1;
        @(negedge clk);
        bus.in_Start = 1'b0;
        lat = -1;
        for (int i = 11; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_Valid) begin
                lat = i;
                break;
            end
        end
        check("ign_lat",   64'(lat), 64'd33);
        check("ign_q",     64'(bus.out_Quotient), 64'd0);
        check("ign_r",     64'(bus.out_Remainder), 64'd5);
        check("ign_flags", 64'(flags_now()), 64'b1000);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        drive(32'h0000_1011, 32'h0000_0010, 1'b0);
        bus.in_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.in_Start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  64'(bus.out_Busy), 64'd0);
        check("arst_valid", 64'(bus.out_Valid), 64'd0);
        check("arst_q",     64'(bus.out_Quotient), 64'd0);
        check("arst_r",     64'(bus.out_Remainder), 64'd0);
        check("arst_flags", 64'(flags_now()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_Valid || bus.out_Busy) seen++;
        end
        check("arst_quiet", 64'(seen), 64'd0);
        run_div(32'h1234_5678, 32'h0000_1000, 1'b0, lat);
        check("arst_lat", 64'(lat), 64'd33);
        check("arst_qr",  {bus.out_Quotient, bus.out_Remainder}, {32'h0001_2345, 32'h0000_0678});

        // Back-to-back with in_Start held high, against a reference model
        @(negedge clk);
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 31);
        drive(ra, rb, 1'b0);
        bus.in_Start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 1000; n++) begin
            wait_valid(lat);
            eq = (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
            er = (rb == 0) ? ra : ra % rb;
            check("b2b_lat", 64'(lat), (rb == 0) ? 64'd2 : 64'd33);
            check("b2b_qr", {bus.out_Quotient, bus.out_Remainder}, {eq, er});
            if (n < 999) begin
                ra = $urandom;
                rb = ($urandom_range(0, 49) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
                drive(ra, rb, 1'b0);
            end else begin
                bus.in_Start = 1'b0;
            end
            @(posedge clk);
            #1;
            check("b2b_accept", 64'(bus.out_Busy), (n < 999) ? 64'd1 : 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
